// File: rtl/fifo_seq_pkg.sv
// Shared types and width helpers for the FIFO-bank sequencer.
// Default geometry is 8 FIFOs x 8 entries x 64 bits.
package fifo_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DIM_DEF   = 8;
  localparam int DEPTH_DEF = 8;
  localparam int BITS_DEF  = 64;

  // Counter width for values 0..n-1. Returns at least 1 so that n = 1 still gives a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_W = cnt_w(DEPTH_DEF);
  localparam int ROW_W  = cnt_w(DIM_DEF);
  localparam int T_W    = cnt_w(DEPTH_DEF + DIM_DEF - 1);

endpackage

// File: rtl/fifo_seq_ctrl_skew_window.sv
// Drain wavefront mask: FIFO i is active while i <= t < i+DEPTH.
module skew_window
  import fifo_seq_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TW    = cnt_w(DEPTH_DEF + DIM_DEF - 1)
) (
  input  logic [TW-1:0]  t,
  output logic [DIM-1:0] win
);

  logic [31:0] t_ext;

  always_comb begin
    t_ext = 32'(t);
    win   = '0;
    for (int i = 0; i < DIM; i++) begin
      win[i] = (t_ext >= 32'(i)) && (t_ext < 32'(i + DEPTH));
    end
  end

endmodule

// File: rtl/fifo_seq_ctrl.sv
// Load/drain sequencer for a bank of DIM shift-register FIFOs.
// Build option FIFO_SEQ_HOLD_EN adds a 'hold' input that freezes the sequence in place.
module fifo_seq_ctrl
  import fifo_seq_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int BITS  = BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef FIFO_SEQ_HOLD_EN
  input  logic                hold,
`endif
  input  logic                in_valid,
  input  logic [BITS-1:0]     in_data,
  output logic                in_ready,
  output logic [DIM-1:0]      fifo_en,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic [DIM-1:0]      col_valid,
  output logic                busy,
  output logic                done
);

  // state | meaning
  // IDLE  | waiting for start, all outputs quiet
  // LOAD  | accepting DEPTH beats per FIFO, row by row
  // DRAIN | skewed shift-out of all FIFOs, zeros shifted in
  // DONE  | one-cycle done pulse, then back to IDLE

  localparam int BW = cnt_w(DEPTH);
  localparam int RW = cnt_w(DIM);
  localparam int TW = cnt_w(DEPTH + DIM - 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(DEPTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DIM - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(DEPTH + DIM - 2);

  state_t          state, state_nxt;
  logic [BW-1:0]   beat, beat_nxt;
  logic [RW-1:0]   row, row_nxt;
  logic [TW-1:0]   t, t_nxt;
  logic [DIM-1:0]  win;
  logic            stall;

`ifdef FIFO_SEQ_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  skew_window #(
    .DIM   (DIM),
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_skew_window (
    .t   (t),
    .win (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      row   <= '0;
      t     <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      row   <= row_nxt;
      t     <= t_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    row_nxt   = row;
    t_nxt     = t;
    in_ready  = 1'b0;
    fifo_en   = '0;
    fifo_d    = '0;
    col_valid = '0;
    done      = 1'b0;
    busy      = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (start && !stall) begin
          state_nxt = LOAD;
          beat_nxt  = '0;
          row_nxt   = '0;
          t_nxt     = '0;
        end
      end

      LOAD: begin
        if (!stall) begin
          in_ready = 1'b1;
          if (in_valid) begin
            // Steer the accepted beat into the FIFO selected by the current row.
            for (int i = 0; i < DIM; i++) begin
              if (row == RW'(i)) begin
                fifo_en[i]             = 1'b1;
                fifo_d[i*BITS +: BITS] = in_data;
              end
            end
            if (beat == BEAT_LAST) begin
              beat_nxt = '0;
              if (row == ROW_LAST) begin
                row_nxt   = '0;
                t_nxt     = '0;
                state_nxt = DRAIN;
              end else begin
                row_nxt = row + 1'b1;
              end
            end else begin
              beat_nxt = beat + 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (!stall) begin
          fifo_en   = win;
          col_valid = win;
          if (t == T_LAST) begin
            t_nxt     = '0;
            state_nxt = DONE;
          end else begin
            t_nxt = t + 1'b1;
          end
        end
      end

      DONE: begin
        if (!stall) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Randomized self-checking bench: real shift FIFOs behind the sequencer, checked against a
// beat-index model of where each beat must land and when it must reappear.
module tb_fifo_seq_ctrl;

  localparam int DIM   = 2;
  localparam int DEPTH = 3;
  localparam int BITS  = 16;
  localparam int NBEAT = DIM * DEPTH;

  logic                clk;
  logic                rst;
  logic                start;
`ifdef FIFO_SEQ_HOLD_EN
  logic                hold;
`endif
  logic                in_valid;
  logic [BITS-1:0]     in_data;
  logic                in_ready;
  logic [DIM-1:0]      fifo_en;
  logic [DIM*BITS-1:0] fifo_d;
  logic [DIM-1:0]      col_valid;
  logic                busy;
  logic                done;

  logic [BITS-1:0] fq  [DIM][DEPTH];
  logic [BITS-1:0] dat [NBEAT];

  int n_chk = 0;
  int n_err = 0;

  fifo_seq_ctrl #(
    .DIM   (DIM),
    .DEPTH (DEPTH),
    .BITS  (BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef FIFO_SEQ_HOLD_EN
    .hold      (hold),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fifo_en   (fifo_en),
    .fifo_d    (fifo_d),
    .col_valid (col_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-register FIFOs: entry 0 takes d, q is the last (oldest) entry.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int k = 0; k < DEPTH; k++) fq[i][k] <= '0;
    end else begin
      for (int i = 0; i < DIM; i++) begin
        if (fifo_en[i]) begin
          fq[i][0] <= fifo_d[i*BITS +: BITS];
          for (int k = 1; k < DEPTH; k++) fq[i][k] <= fq[i][k-1];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fifos_empty(input string tag);
    for (int i = 0; i < DIM; i++) chk(tag, 64'(fq[i][DEPTH-1]), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_en"}, 64'(fifo_en), 64'd0);
    chk({tag, "_cv"}, 64'(col_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Model: beat n goes to FIFO n/DEPTH.
  task automatic load(input int gap_at, input int gap_len, input bit rnd);
    logic [DIM-1:0]      exp_en;
    logic [DIM*BITS-1:0] exp_d;
    int                  g;
    start    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    tick;
    start = 1'b0;
    for (int n = 0; n < NBEAT; n++) begin
      g = (n == gap_at) ? gap_len : 0;
      if (rnd) g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = BITS'($urandom);
        #1;
        chk("gap_en", 64'(fifo_en), 64'd0);
        chk("gap_ready", 64'(in_ready), 64'd1);
        tick;
      end
      in_valid = 1'b1;
      in_data  = dat[n];
      #1;
      exp_en = '0;
      exp_en[n / DEPTH] = 1'b1;
      exp_d = '0;
      exp_d[(n / DEPTH)*BITS +: BITS] = dat[n];
      chk("load_ready", 64'(in_ready), 64'd1);
      chk("load_en", 64'(fifo_en), 64'(exp_en));
      chk("load_d", 64'(fifo_d), 64'(exp_d));
      chk("load_busy", 64'(busy), 64'd1);
      tick;
    end
    in_valid = 1'b0;
    #1;
    chk("ready_drop", 64'(in_ready), 64'd0);
  endtask

  // Model: FIFO i is valid for i <= t < i+DEPTH and shows beat i*DEPTH + (t-i).
  task automatic drain(input int start_at, input int rst_at, input int hold_at);
    logic [DIM-1:0] exp_m;
    for (int t = 0; t <= DEPTH + DIM - 2; t++) begin
`ifdef FIFO_SEQ_HOLD_EN
      if (t == hold_at) begin
        hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
          #1;
          chk("hold_en", 64'(fifo_en), 64'd0);
          chk("hold_cv", 64'(col_valid), 64'd0);
          chk("hold_busy", 64'(busy), 64'd1);
          tick;
        end
        hold = 1'b0;
      end
`endif
      start = (t == start_at);
      #1;
      exp_m = '0;
      for (int i = 0; i < DIM; i++) exp_m[i] = (t >= i) && (t < i + DEPTH);
      chk("drain_cv", 64'(col_valid), 64'(exp_m));
      chk("drain_en", 64'(fifo_en), 64'(exp_m));
      chk("drain_d", 64'(fifo_d), 64'd0);
      chk("drain_ready", 64'(in_ready), 64'd0);
      chk("drain_done", 64'(done), 64'd0);
      for (int i = 0; i < DIM; i++)
        if (exp_m[i]) chk("drain_q", 64'(fq[i][DEPTH-1]), 64'(dat[i*DEPTH + t - i]));
      if (t == rst_at) begin
        rst = 1'b1;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk_quiet("midrst");
        chk_fifos_empty("midrst_q");
        return;
      end
      tick;
      start = 1'b0;
    end
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_en", 64'(fifo_en), 64'd0);
    tick;
    chk_quiet("after_done");
    chk_fifos_empty("after_done_q");
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef FIFO_SEQ_HOLD_EN
    hold     = 1'b0;
`endif
    tick;
    tick;
    start = 1'b0;
    rst   = 1'b0;
    #1;
    chk_quiet("reset");

    for (int k = 0; k < NBEAT; k++) dat[k] = BITS'(k + 1);
    load(-1, 0, 1'b0);
    drain(-1, -1, -1);

    load(2, 2, 1'b0);
    drain(-1, -1, -1);

    load(-1, 0, 1'b0);
    drain(1, -1, -1);

    load(-1, 0, 1'b0);
    drain(-1, 1, -1);
    load(-1, 0, 1'b0);
    drain(-1, -1, -1);

`ifdef FIFO_SEQ_HOLD_EN
    load(-1, 0, 1'b0);
    drain(-1, -1, 1);
`endif

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NBEAT; k++) dat[k] = BITS'($urandom);
      repeat ($urandom_range(0, 3)) begin
        #1;
        chk("idle_wait", 64'(busy), 64'd0);
        tick;
      end
      load(-1, 0, 1'b1);
      drain(-1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
